execute_stage: RTL and testbench

//  Registered, handshaked successor to the single-cycle execute unit of the RV32I core.

---
 rtl/execute_pkg.sv | 25 ++
 rtl/serial_shifter.sv | 71 +++++++
 rtl/execute_stage.sv | 211 +++++++++++++++++++++
 tb/tb_execute_stage.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/execute_pkg.sv
// Shared encodings for the execute stage: ALU and branch funct3 codes and FSM states.
package execute_pkg;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/serial_shifter.sv
// Multi-cycle barrel-free shifter: moves SHIFT_STEP bits per cycle until shamt is consumed.
module serial_shifter #(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic                    dir_i,
  input  logic                    arith_i,
  input  logic [$clog2(XLEN)-1:0] shamt_i,
  input  logic [XLEN-1:0]         value_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [XLEN-1:0]         value_o
);

  localparam int SW     = $clog2(XLEN);
  localparam int STEP_C = (SHIFT_STEP < XLEN) ? SHIFT_STEP : XLEN - 1;
  localparam logic [SW-1:0] STEP_AMT = SW'(STEP_C);

  logic [XLEN-1:0] val_q;
  logic [SW-1:0]   rem_q;
  logic            dir_q;
  logic            arith_q;
  logic            active_q;

  logic            last;
  logic [SW-1:0]   amt;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] sra_val;

  // The final step shifts only the remainder so shamt need not be a multiple of the step.
  assign last    = active_q && (rem_q <= STEP_AMT);
  assign amt     = last ? rem_q : STEP_AMT;
  assign sra_val = $signed(val_q) >>> amt;

  always_comb begin
    shifted = val_q << amt;
    if (dir_q) begin
      shifted = arith_q ? sra_val : (val_q >> amt);
    end
  end

  assign busy_o  = active_q;
  assign done_o  = last;
  assign value_o = shifted;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q    <= '0;
      rem_q    <= '0;
      dir_q    <= 1'b0;
      arith_q  <= 1'b0;
      active_q <= 1'b0;
    end else if (start_i) begin
      val_q    <= value_i;
      rem_q    <= shamt_i;
      dir_q    <= dir_i;
      arith_q  <= arith_i;
      active_q <= 1'b1;
    end else if (active_q) begin
      val_q <= shifted;
      rem_q <= rem_q - amt;
      if (last) begin
        active_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/execute_stage.sv
// Registered RV32I execute stage: ALU, address generation, branch/jump resolution,
// with shifts optionally routed through a serial shifter.
module execute_stage
  import execute_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter int              REG_ADDR_W = 5,
  parameter int              SHIFT_STEP = 1,
  parameter logic [XLEN-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  is_branch,
  input  logic                  is_jump,
  input  logic                  is_load,
  input  logic                  is_store,
  input  logic                  is_reg,
  input  logic                  is_alu,
  input  logic [2:0]            func3,
  input  logic                  func7,
  input  logic [XLEN-1:0]       operand_a,
  input  logic [XLEN-1:0]       operand_b,
  input  logic [XLEN-1:0]       branch_dest,
  input  logic [XLEN-1:0]       curr_pc,
  input  logic [REG_ADDR_W-1:0] dest_i,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       result,
  output logic [REG_ADDR_W-1:0] dest_o,
  output logic [XLEN-1:0]       next_pc,
  output logic                  branch_taken,
  output logic                  busy,
  output logic                  dbg_state
);

  localparam int              SW     = $clog2(XLEN);
  localparam bit              SERIAL = (SHIFT_STEP < XLEN);
  localparam logic [XLEN-1:0] FOUR   = XLEN'(4);

  state_e                state_q;
  logic                  out_valid_q;
  logic [XLEN-1:0]       result_q;
  logic [REG_ADDR_W-1:0] dest_q;
  logic [XLEN-1:0]       npc_q;
  logic                  taken_q;
  logic [REG_ADDR_W-1:0] dest_pend_q;
  logic [XLEN-1:0]       npc_pend_q;

  logic c_branch, c_jump, c_load, c_store, c_alu;
  logic accept, is_shift, go_serial;
  logic eq, lt, ltu, br_cond;
  logic [SW-1:0]   shamt;
  logic [XLEN-1:0] pc_plus4, pc_plus_off, a_plus_off, sra_val, alu_res;
  logic [XLEN-1:0]       res_d, npc_d;
  logic [REG_ADDR_W-1:0] dest_d;
  logic                  taken_d;
  logic                  sh_busy, sh_done;
  logic [XLEN-1:0]       sh_value;

  // Handshake: a transfer happens on a rising edge where valid && ready; input fields
  // must stay stable while in_valid is high and in_ready is low, and the stage holds
  // its outputs while out_valid is high and out_ready is low.
  assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  assign c_branch = is_branch;
  assign c_jump   = !is_branch && is_jump;
  assign c_load   = !is_branch && !is_jump && is_load;
  assign c_store  = !is_branch && !is_jump && !is_load && is_store;
  assign c_alu    = !is_branch && !is_jump && !is_load && !is_store && is_alu;

  assign shamt     = operand_b[SW-1:0];
  assign is_shift  = (func3 == F3_SLL) || (func3 == F3_SRL);
  assign go_serial = SERIAL && c_alu && is_shift && (shamt != '0);

  assign pc_plus4    = curr_pc + FOUR;
  assign pc_plus_off = curr_pc + branch_dest;
  assign a_plus_off  = operand_a + branch_dest;

  assign eq      = (operand_a == operand_b);
  assign lt      = ($signed(operand_a) < $signed(operand_b));
  assign ltu     = (operand_a < operand_b);
  assign sra_val = $signed(operand_a) >>> shamt;

  always_comb begin
    br_cond = 1'b0;
    case (func3)
      F3_BEQ:  br_cond = eq;
      F3_BNE:  br_cond = !eq;
      F3_BLT:  br_cond = lt;
      F3_BGE:  br_cond = !lt;
      F3_BLTU: br_cond = ltu;
      F3_BGEU: br_cond = !ltu;
      default: br_cond = 1'b0;
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (func3)
      F3_ADD:  alu_res = (is_reg && func7) ? (operand_a - operand_b) : (operand_a + operand_b);
      F3_SLL:  alu_res = operand_a << shamt;
      F3_SLT:  alu_res = {{(XLEN-1){1'b0}}, lt};
      F3_SLTU: alu_res = {{(XLEN-1){1'b0}}, ltu};
      F3_XOR:  alu_res = operand_a ^ operand_b;
      F3_SRL:  alu_res = func7 ? sra_val : (operand_a >> shamt);
      F3_OR:   alu_res = operand_a | operand_b;
      F3_AND:  alu_res = operand_a & operand_b;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    res_d   = '0;
    dest_d  = '0;
    npc_d   = pc_plus4;
    taken_d = 1'b0;
    if (c_branch) begin
      taken_d = br_cond;
      if (br_cond) begin
        npc_d = pc_plus_off;
      end
    end else if (c_jump) begin
      res_d   = pc_plus4;
      dest_d  = dest_i;
      taken_d = 1'b1;
      npc_d   = is_reg ? {a_plus_off[XLEN-1:1], 1'b0} : pc_plus_off;
    end else if (c_load) begin
      res_d  = a_plus_off;
      dest_d = dest_i;
    end else if (c_store) begin
      res_d = a_plus_off;
    end else if (c_alu) begin
      res_d  = alu_res;
      dest_d = dest_i;
    end
  end

  serial_shifter #(
    .XLEN       (XLEN),
    .SHIFT_STEP (SHIFT_STEP)
  ) u_shifter (
    .clk     (clk),
    .rst_n   (reset),
    .start_i (accept && go_serial),
    .dir_i   (func3 == F3_SRL),
    .arith_i (func7),
    .shamt_i (shamt),
    .value_i (operand_a),
    .busy_o  (sh_busy),
    .done_o  (sh_done),
    .value_o (sh_value)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      dest_q      <= '0;
      npc_q       <= RESET_PC;
      taken_q     <= 1'b0;
      dest_pend_q <= '0;
      npc_pend_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
          end
          if (accept) begin
            if (go_serial) begin
              // Output fields other than the shifted value are known now; park them.
              state_q     <= ST_SHIFT;
              dest_pend_q <= dest_i;
              npc_pend_q  <= pc_plus4;
            end else begin
              out_valid_q <= 1'b1;
              result_q    <= res_d;
              dest_q      <= dest_d;
              npc_q       <= npc_d;
              taken_q     <= taken_d;
            end
          end
        end
        ST_SHIFT: begin
          if (sh_done) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b1;
            result_q    <= sh_value;
            dest_q      <= dest_pend_q;
            npc_q       <= npc_pend_q;
            taken_q     <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_valid    = out_valid_q;
  assign result       = result_q;
  assign dest_o       = dest_q;
  assign next_pc      = npc_q;
  assign branch_taken = taken_q;
  assign busy         = sh_busy;
  assign dbg_state    = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: directed vectors plus randomized traffic checked
// against an instruction-level reference model.
module tb_execute_stage;

  localparam int W = 70;  // {result[31:0], dest[4:0], next_pc[31:0], taken}

  logic        clk;
  logic        reset;
  logic        in_valid, in_ready;
  logic        is_branch, is_jump, is_load, is_store, is_reg, is_alu;
  logic [2:0]  func3;
  logic        func7;
  logic [31:0] operand_a, operand_b, branch_dest, curr_pc;
  logic [4:0]  dest_i;
  logic        out_valid, out_ready;
  logic [31:0] result, next_pc;
  logic [4:0]  dest_o;
  logic        branch_taken, busy, dbg_state;

  logic        in_valid_f, in_ready_f, out_valid_f;
  logic [31:0] result_f, npc_f;
  logic [4:0]  dest_f;
  logic        taken_f, busy_f, dbg_f;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_err    = 0;
  int rdy_mode = 1;  // 0: random out_ready, otherwise driven by the main sequence
  bit mon_en   = 1;

  execute_stage #(.XLEN(32), .REG_ADDR_W(5), .SHIFT_STEP(1), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .is_branch(is_branch), .is_jump(is_jump), .is_load(is_load), .is_store(is_store),
    .is_reg(is_reg), .is_alu(is_alu), .func3(func3), .func7(func7),
    .operand_a(operand_a), .operand_b(operand_b), .branch_dest(branch_dest),
    .curr_pc(curr_pc), .dest_i(dest_i), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .dest_o(dest_o), .next_pc(next_pc), .branch_taken(branch_taken),
    .busy(busy), .dbg_state(dbg_state)
  );

  execute_stage #(.XLEN(32), .REG_ADDR_W(5), .SHIFT_STEP(32), .RESET_PC(32'h0)) dut_fast (
    .clk(clk), .reset(reset), .in_valid(in_valid_f), .in_ready(in_ready_f),
    .is_branch(is_branch), .is_jump(is_jump), .is_load(is_load), .is_store(is_store),
    .is_reg(is_reg), .is_alu(is_alu), .func3(func3), .func7(func7),
    .operand_a(operand_a), .operand_b(operand_b), .branch_dest(branch_dest),
    .curr_pc(curr_pc), .dest_i(dest_i), .out_valid(out_valid_f), .out_ready(1'b1),
    .result(result_f), .dest_o(dest_f), .next_pc(npc_f), .branch_taken(taken_f),
    .busy(busy_f), .dbg_state(dbg_f)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: one decoded instruction in, architectural outcome out.
  function automatic logic [W-1:0] model();
    logic [31:0] r, npc;
    logic [4:0]  d;
    logic        t, c;
    logic [4:0]  sh;
    r = 32'd0; d = 5'd0; npc = curr_pc + 32'd4; t = 1'b0; c = 1'b0;
    sh = operand_b[4:0];
    if (is_branch) begin
      case (func3)
        3'd0: c = (operand_a == operand_b);
        3'd1: c = (operand_a != operand_b);
        3'd4: c = ($signed(operand_a) < $signed(operand_b));
        3'd5: c = ($signed(operand_a) >= $signed(operand_b));
        3'd6: c = (operand_a < operand_b);
        3'd7: c = (operand_a >= operand_b);
        default: c = 1'b0;
      endcase
      t = c;
      if (c) npc = curr_pc + branch_dest;
    end else if (is_jump) begin
      r = curr_pc + 32'd4;
      d = dest_i;
      t = 1'b1;
      npc = is_reg ? ((operand_a + branch_dest) & 32'hFFFF_FFFE) : (curr_pc + branch_dest);
    end else if (is_load) begin
      r = operand_a + branch_dest;
      d = dest_i;
    end else if (is_store) begin
      r = operand_a + branch_dest;
    end else if (is_alu) begin
      d = dest_i;
      case (func3)
        3'd0: r = (is_reg && func7) ? operand_a - operand_b : operand_a + operand_b;
        3'd1: r = operand_a << sh;
        3'd2: r = ($signed(operand_a) < $signed(operand_b)) ? 32'd1 : 32'd0;
        3'd3: r = (operand_a < operand_b) ? 32'd1 : 32'd0;
        3'd4: r = operand_a ^ operand_b;
        3'd5: r = func7 ? 32'($signed(operand_a) >>> sh) : (operand_a >> sh);
        3'd6: r = operand_a | operand_b;
        default: r = operand_a & operand_b;
      endcase
    end
    return {r, d, npc, t};
  endfunction

  // Driver tasks
  task automatic drive(input logic [5:0] fl, input logic [2:0] f3, input logic f7,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] off,
                       input logic [31:0] pc, input logic [4:0] rd);
    {is_branch, is_jump, is_load, is_store, is_reg, is_alu} = fl;
    func3 = f3; func7 = f7; operand_a = a; operand_b = b;
    branch_dest = off; curr_pc = pc; dest_i = rd;
  endtask

  task automatic send(input bit use_c, input logic [W-1:0] exp_c);
    logic [W-1:0] e;
    e = use_c ? exp_c : model();
    in_valid = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    n_checks++;
    n_err++;
    $display("FAIL accept_timeout: in_ready stayed 0 for 300 cycles, required 1");
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard monitor: whenever a result is presented it must match the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && out_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL out_unexpected: got result %h with empty queue, required none", result);
        end else begin
          chk("out", {result, dest_o, next_pc, branch_taken}, exp_q[0]);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int busy_cnt;
    int sel;
    logic [5:0] fl;
    reset = 1'b0; in_valid = 1'b0; in_valid_f = 1'b0; out_ready = 1'b1;
    drive(6'b0, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0);
    @(negedge clk);
    chk("reset_outputs", {out_valid, result, dest_o, next_pc, branch_taken, busy, dbg_state},
        {1'b0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0});
    idle(2);
    reset = 1'b1;
    @(negedge clk);
    chk("in_ready_after_reset", in_ready, 1);

    // Branches
    @(posedge clk); #1;
    drive(6'b100000, 3'd0, 1'b0, 32'd200, 32'd200, 32'd20, 32'd20, 5'd7);
    send(1, {32'd0, 5'd0, 32'd40, 1'b1});
    drive(6'b100000, 3'd6, 1'b0, 32'd2200000000, 32'd10, 32'd20, 32'd20, 5'd7);
    send(1, {32'd0, 5'd0, 32'd24, 1'b0});
    drive(6'b100000, 3'd4, 1'b0, 32'd100, -32'sd300, 32'd8, 32'd0, 5'd3);
    send(1, {32'd0, 5'd0, 32'd4, 1'b0});
    drive(6'b100000, 3'd5, 1'b0, 32'd100, 32'd100, 32'd16, 32'd12, 5'd3);
    send(1, {32'd0, 5'd0, 32'd28, 1'b1});

    // JALR, wrapping ADD, load/store, rd=0
    drive(6'b010010, 3'd0, 1'b0, 32'h1001, 32'd0, 32'd4, 32'd8, 5'd1);
    send(1, {32'd12, 5'd1, 32'h1004, 1'b1});
    drive(6'b000001, 3'd0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFC, 5'd5);
    send(1, {32'd0, 5'd5, 32'd0, 1'b0});
    drive(6'b001000, 3'd2, 1'b0, 32'h100, 32'd0, 32'h24, 32'h30, 5'd9);
    send(1, {32'h124, 5'd9, 32'h34, 1'b0});
    drive(6'b000100, 3'd2, 1'b0, 32'h100, 32'd0, 32'h24, 32'h30, 5'd9);
    send(1, {32'h124, 5'd0, 32'h34, 1'b0});
    drive(6'b000001, 3'd4, 1'b0, 32'hF0F0, 32'h0FF0, 32'd0, 32'h50, 5'd0);
    send(1, {32'hFF00, 5'd0, 32'h54, 1'b0});
    idle(3);

    // Serial SRA: four busy cycles then the result
    drive(6'b000001, 3'd5, 1'b1, 32'h8000_0000, 32'd4, 32'd0, 32'h40, 5'd3);
    send(1, {32'hF800_0000, 5'd3, 32'h44, 1'b0});
    busy_cnt = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (out_valid) break;
      if (busy) busy_cnt++;
    end
    chk("sra_busy_cycles", busy_cnt, 4);
    idle(2);

    // Same SRA on the single-cycle configuration
    in_valid_f = 1'b1;
    @(posedge clk); #1;
    in_valid_f = 1'b0;
    @(negedge clk);
    chk("fast_sra", {out_valid_f, result_f, dest_f, npc_f, taken_f, busy_f},
        {1'b1, 32'hF800_0000, 5'd3, 32'h44, 1'b0, 1'b0});
    @(posedge clk); #1;

    // Downstream stall with a waiting instruction, then release
    out_ready = 1'b0;
    drive(6'b000001, 3'd7, 1'b0, 32'h00FF_00FF, 32'h0F0F_0F0F, 32'd0, 32'h80, 5'd11);
    send(1, {32'h000F_000F, 5'd11, 32'h84, 1'b0});
    drive(6'b000001, 3'd6, 1'b0, 32'h00FF_0000, 32'h0000_00FF, 32'd0, 32'h84, 5'd12);
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready", in_ready, 1);
    if (in_ready) exp_q.push_back({32'h00FF_00FF, 5'd12, 32'h88, 1'b0});
    @(posedge clk); #1;
    in_valid = 1'b0;
    idle(3);

    // Reset in the middle of a long shift
    drive(6'b000001, 3'd1, 1'b0, 32'd1, 32'd20, 32'd0, 32'd0, 5'd2);
    send(1, {32'h0010_0000, 5'd2, 32'd4, 1'b0});
    idle(5);
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("reset_mid_shift", {out_valid, result, dest_o, next_pc, branch_taken, busy, dbg_state},
        {1'b0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0});
    @(posedge clk); #3;
    reset = 1'b1;
    @(negedge clk);
    chk("in_ready_after_abort", in_ready, 1);
    idle(30);
    @(negedge clk);
    chk("no_output_after_abort", out_valid, 0);
    @(posedge clk); #1;

    // Randomized traffic with random downstream backpressure
    rdy_mode = 0;
    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 6);
      fl = 6'b0;
      case (sel)
        0: fl[5] = 1'b1;
        1: fl[4] = 1'b1;
        2: fl[3] = 1'b1;
        3: fl[2] = 1'b1;
        4, 5: fl[0] = 1'b1;
        default: fl = 6'b0;
      endcase
      fl[1] = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) fl[$urandom_range(0, 5)] = 1'b1;
      drive(fl, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom(), $urandom(),
            $urandom(), {$urandom() >> 2, 2'b00}, 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 3) == 0) operand_b = operand_a;
      if ($urandom_range(0, 3) == 0) operand_b = 32'($urandom_range(0, 31));
      send(0, '0);
      idle($urandom_range(0, 2) == 0 ? $urandom_range(1, 2) : 0);
    end

    // Drain
    rdy_mode = 1;
    out_ready = 1'b1;
    for (int k = 0; k < 500 && exp_q.size() != 0; k++) idle(1);
    idle(2);
    chk("drain_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
